// File: rtl/exe_mem_stage.sv
// EX/MEM pipeline boundary: registers the ALU result with its control bundle,
// resolves branches/jumps into a one-cycle redirect, and aligns store data.
module exe_mem_stage #(
  parameter int unsigned N           = 64,
  parameter int unsigned LINK_OFFSET = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ex_valid,
  output logic         ex_ready,
  input  logic [N-1:0] ex_alu_result,
  input  logic         ex_zero,
  input  logic [N-1:0] ex_pc,
  input  logic [N-1:0] ex_imm,
  input  logic [N-1:0] ex_rs2_data,
  input  logic [4:0]   ex_rd,
  input  logic [2:0]   ex_funct3,
  input  logic         ex_is_branch,
  input  logic         ex_is_jal,
  input  logic         ex_is_jalr,
  input  logic         ex_mem_read,
  input  logic         ex_mem_write,
  input  logic         ex_reg_write,
  output logic         mem_valid,
  input  logic         mem_ready,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  output logic [7:0]   mem_be,
  output logic [N-1:0] mem_wb_data,
  output logic [4:0]   mem_rd,
  output logic [2:0]   mem_funct3,
  output logic         mem_mem_read,
  output logic         mem_mem_write,
  output logic         mem_reg_write,
  output logic [1:0]   mem_exc,
  output logic         redirect_valid,
  output logic [N-1:0] redirect_pc
);

  logic         taken;
  logic         tgt_mis;
  logic         ls_mis;
  logic         store_ok;
  logic         no_exc;
  logic         capture;
  logic [N-1:0] target;
  logic [7:0]   mask;
  logic [1:0]   exc_n;
  logic [7:0]   be_n;
  logic [N-1:0] wdata_n;
  logic [N-1:0] wb_n;

  // A pending redirect means the EX bundle is the shadow instruction: take it and drop it.
  assign ex_ready = redirect_valid | ~mem_valid | mem_ready;
  assign capture  = ex_valid & ex_ready & ~redirect_valid;

  // Branch resolution, alignment checks and store lane steering for the incoming bundle.
  always_comb begin
    taken    = (ex_is_branch & ex_zero) | ex_is_jal | ex_is_jalr;
    target   = ex_is_jalr ? {ex_alu_result[N-1:1], 1'b0} : ex_pc + ex_imm;
    tgt_mis  = taken & target[1];
    mask     = 8'h00;
    ls_mis   = 1'b0;
    case (ex_funct3[1:0])
      2'd0: begin mask = 8'h01; ls_mis = 1'b0;                   end
      2'd1: begin mask = 8'h03; ls_mis = ex_alu_result[0];       end
      2'd2: begin mask = 8'h0F; ls_mis = |ex_alu_result[1:0];    end
      default: begin mask = 8'hFF; ls_mis = |ex_alu_result[2:0]; end
    endcase
    exc_n = 2'd0;
    if (tgt_mis)                    exc_n = 2'd1;
    else if (ex_mem_read & ls_mis)  exc_n = 2'd2;
    else if (ex_mem_write & ls_mis) exc_n = 2'd3;
    no_exc   = (exc_n == 2'd0);
    store_ok = ex_mem_write & no_exc;
    be_n     = store_ok ? 8'(mask << ex_alu_result[2:0]) : 8'h00;
    wdata_n  = store_ok ? (ex_rs2_data << {ex_alu_result[2:0], 3'b000}) : '0;
    wb_n     = (ex_is_jal | ex_is_jalr) ? ex_pc + N'(LINK_OFFSET) : ex_alu_result;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid      <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_be         <= 8'h00;
      mem_wb_data    <= '0;
      mem_rd         <= 5'd0;
      mem_funct3     <= 3'd0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_reg_write  <= 1'b0;
      mem_exc        <= 2'd0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      if (capture) begin
        mem_valid     <= 1'b1;
        mem_addr      <= ex_alu_result;
        mem_wdata     <= wdata_n;
        mem_be        <= be_n;
        mem_wb_data   <= wb_n;
        mem_rd        <= ex_rd;
        mem_funct3    <= ex_funct3;
        mem_mem_read  <= ex_mem_read & no_exc;
        mem_mem_write <= ex_mem_write & no_exc;
        mem_reg_write <= ex_reg_write & no_exc;
        mem_exc       <= exc_n;
        redirect_pc   <= target;
      end else if (mem_ready) begin
        mem_valid <= 1'b0;
      end
      // Only a fresh capture can raise the pulse, so a stalled jump redirects once.
      redirect_valid <= capture & taken & ~tgt_mis;
    end
  end

endmodule

// File: tb/tb_exe_mem_stage.sv
// Bench for exe_mem_stage: directed vector table, corner-case sequences, and
// randomized traffic against a transaction-level reference model.
module tb_exe_mem_stage;
  localparam int unsigned N = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         ex_valid;
  logic         ex_ready;
  logic [N-1:0] ex_alu_result, ex_pc, ex_imm, ex_rs2_data;
  logic         ex_zero;
  logic [4:0]   ex_rd;
  logic [2:0]   ex_funct3;
  logic         ex_is_branch, ex_is_jal, ex_is_jalr, ex_mem_read, ex_mem_write, ex_reg_write;
  logic         mem_valid, mem_ready;
  logic [N-1:0] mem_addr, mem_wdata, mem_wb_data, redirect_pc;
  logic [7:0]   mem_be;
  logic [4:0]   mem_rd;
  logic [2:0]   mem_funct3;
  logic         mem_mem_read, mem_mem_write, mem_reg_write, redirect_valid;
  logic [1:0]   mem_exc;

  exe_mem_stage #(.N(N), .LINK_OFFSET(4)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_result(ex_alu_result), .ex_zero(ex_zero), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
    .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_wb_data(mem_wb_data), .mem_rd(mem_rd), .mem_funct3(mem_funct3),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write), .mem_reg_write(mem_reg_write),
    .mem_exc(mem_exc), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] alu, pc, imm, rs2;
    logic        zero;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        br, jal, jalr, mr, mw, rw;
  } ins_t;

  typedef struct {
    logic [63:0] addr, wdata, wb, rpc;
    logic [7:0]  be;
    logic [1:0]  exc;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        mr, mw, rw, redir;
  } exp_t;

  typedef struct {
    ins_t in;
    exp_t ex;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic ins_t mk_ins(input logic [63:0] alu, pc, imm, rs2, input logic zero,
                                  input logic [2:0] f3, input logic br, jal, jalr, mr, mw, rw);
    ins_t i;
    i.alu = alu; i.pc = pc; i.imm = imm; i.rs2 = rs2; i.zero = zero; i.rd = 5'd7; i.f3 = f3;
    i.br = br; i.jal = jal; i.jalr = jalr; i.mr = mr; i.mw = mw; i.rw = rw;
    return i;
  endfunction

  function automatic exp_t mk_exp(input logic [63:0] addr, wdata, wb, rpc, input logic [7:0] be,
                                  input logic [1:0] exc, input logic [2:0] f3,
                                  input logic mr, mw, rw, redir);
    exp_t e;
    e.addr = addr; e.wdata = wdata; e.wb = wb; e.rpc = rpc; e.be = be; e.exc = exc;
    e.rd = 5'd7; e.f3 = f3; e.mr = mr; e.mw = mw; e.rw = rw; e.redir = redir;
    return e;
  endfunction

  // Reference: derived directly from the architectural rules with plain arithmetic.
  function automatic exp_t ref_fn(input ins_t i);
    exp_t        e;
    int          size, off;
    logic        taken, tmis, misal, ok;
    logic [63:0] tgt;
    size  = 1 << int'(i.f3[1:0]);
    off   = int'(i.alu[2:0]);
    misal = (off % size) != 0;
    tgt   = i.jalr ? i.alu - (i.alu % 2) : i.pc + i.imm;
    taken = (i.br && i.zero) || i.jal || i.jalr;
    tmis  = taken && ((tgt % 4) >= 2);
    if (tmis) e.exc = 2'd1;
    else if ((i.mr || i.mw) && misal) e.exc = i.mr ? 2'd2 : 2'd3;
    else e.exc = 2'd0;
    ok      = (e.exc == 2'd0);
    e.mr    = i.mr && ok;
    e.mw    = i.mw && ok;
    e.rw    = i.rw && ok;
    e.be    = (i.mw && ok) ? 8'(((1 << size) - 1) << off) : 8'h00;
    e.wdata = (i.mw && ok) ? i.rs2 << (8 * off) : 64'h0;
    e.wb    = (i.jal || i.jalr) ? i.pc + 64'd4 : i.alu;
    e.addr  = i.alu;
    e.rd    = i.rd;
    e.f3    = i.f3;
    e.redir = taken && !tmis;
    e.rpc   = tgt;
    return e;
  endfunction

  function automatic ins_t rnd_ins();
    ins_t       i;
    logic [11:0] t;
    int         kind;
    kind = int'($urandom % 6);
    t    = 12'($urandom);
    i = mk_ins({$urandom, $urandom}, {32'h0, $urandom}, {{52{t[11]}}, t}, {$urandom, $urandom},
               1'($urandom), 3'($urandom % 7), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    i.rd = 5'($urandom);
    case (kind)
      0: i.rw = 1'b1;
      1: begin i.mr = 1'b1; i.rw = 1'b1; end
      2: begin i.mw = 1'b1; i.f3 = 3'($urandom % 4); end
      3: i.br = 1'b1;
      4: begin i.jal = 1'b1; i.rw = 1'b1; end
      default: begin i.jalr = 1'b1; i.rw = 1'b1; end
    endcase
    return i;
  endfunction

  task automatic drive(input ins_t i, input logic v);
    ex_valid = v; ex_alu_result = i.alu; ex_pc = i.pc; ex_imm = i.imm; ex_rs2_data = i.rs2;
    ex_zero = i.zero; ex_rd = i.rd; ex_funct3 = i.f3; ex_is_branch = i.br; ex_is_jal = i.jal;
    ex_is_jalr = i.jalr; ex_mem_read = i.mr; ex_mem_write = i.mw; ex_reg_write = i.rw;
  endtask

  task automatic check_bundle(input string tag, input exp_t e);
    chk($sformatf("%s.addr", tag), mem_addr, e.addr);
    chk($sformatf("%s.wdata", tag), mem_wdata, e.wdata);
    chk($sformatf("%s.be", tag), 64'(mem_be), 64'(e.be));
    chk($sformatf("%s.wb", tag), mem_wb_data, e.wb);
    chk($sformatf("%s.rd", tag), 64'(mem_rd), 64'(e.rd));
    chk($sformatf("%s.f3", tag), 64'(mem_funct3), 64'(e.f3));
    chk($sformatf("%s.mr", tag), 64'(mem_mem_read), 64'(e.mr));
    chk($sformatf("%s.mw", tag), 64'(mem_mem_write), 64'(e.mw));
    chk($sformatf("%s.rw", tag), 64'(mem_reg_write), 64'(e.rw));
    chk($sformatf("%s.exc", tag), 64'(mem_exc), 64'(e.exc));
  endtask

  task automatic check_zero(input string tag);
    exp_t z;
    z = mk_exp(64'h0, 64'h0, 64'h0, 64'h0, 8'h00, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    z.rd = 5'd0;
    check_bundle(tag, z);
    chk($sformatf("%s.valid", tag), 64'(mem_valid), 64'h0);
    chk($sformatf("%s.redir", tag), 64'(redirect_valid), 64'h0);
    chk($sformatf("%s.rpc", tag), redirect_pc, 64'h0);
  endtask

  vec_t vecs[12];
  ins_t idle_i, ld_i, br_i;
  exp_t cur;
  ins_t ri;
  logic mv, rv, ev, mrdy, cap, exp_ready;
  int   pulses;

  initial begin
    idle_i = mk_ins(64'h0, 64'h0, 64'h0, 64'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ld_i   = mk_ins(64'h1000, 64'h80, 64'h0, 64'h0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    br_i   = mk_ins(64'h55, 64'h400, 64'h20, 64'h0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    vecs[0].in  = ld_i;
    vecs[0].ex  = mk_exp(64'h1000, 64'h0, 64'h1000, 64'h0, 8'h00, 2'd0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    vecs[1].in  = mk_ins(64'h1004, 64'h84, 64'h4, 64'hAABBCCDD, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    vecs[1].ex  = mk_exp(64'h1004, 64'hAABBCCDD_00000000, 64'h1004, 64'h0, 8'hF0, 2'd0, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    vecs[2].in  = mk_ins(64'h0, 64'h200, 64'h40, 64'h0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[2].ex  = mk_exp(64'h0, 64'h0, 64'h0, 64'h240, 8'h00, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    vecs[3].in  = mk_ins(64'h0, 64'h200, 64'h42, 64'h0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[3].ex  = mk_exp(64'h0, 64'h0, 64'h0, 64'h0, 8'h00, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[4].in  = mk_ins(64'h301, 64'h100, 64'h7, 64'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    vecs[4].ex  = mk_exp(64'h301, 64'h0, 64'h104, 64'h300, 8'h00, 2'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    vecs[5].in  = mk_ins(64'h1003, 64'h88, 64'h3, 64'h1234, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    vecs[5].ex  = mk_exp(64'h1003, 64'h0, 64'h1003, 64'h0, 8'h00, 2'd3, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[6].in  = mk_ins(64'h1002, 64'h8C, 64'h2, 64'h0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    vecs[6].ex  = mk_exp(64'h1002, 64'h0, 64'h1002, 64'h0, 8'h00, 2'd2, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[7].in  = mk_ins(64'h0, 64'h200, 64'h2, 64'h0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    vecs[7].ex  = mk_exp(64'h0, 64'h0, 64'h204, 64'h0, 8'h00, 2'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[8].in  = mk_ins(64'h1007, 64'h90, 64'h7, 64'h11223344_55667755, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    vecs[8].ex  = mk_exp(64'h1007, 64'h55000000_00000000, 64'h1007, 64'h0, 8'h80, 2'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    vecs[9].in  = mk_ins(64'h1008, 64'h94, 64'h8, 64'h01234567_89ABCDEF, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    vecs[9].ex  = mk_exp(64'h1008, 64'h01234567_89ABCDEF, 64'h1008, 64'h0, 8'hFF, 2'd0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    vecs[10].in = mk_ins(64'h1006, 64'h98, 64'h6, 64'h0, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    vecs[10].ex = mk_exp(64'h1006, 64'h0, 64'h1006, 64'h0, 8'h00, 2'd0, 3'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    vecs[11].in = mk_ins(64'h303, 64'h100, 64'h0, 64'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    vecs[11].ex = mk_exp(64'h303, 64'h0, 64'h104, 64'h0, 8'h00, 2'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    rst = 1'b1; mem_ready = 1'b1;
    drive(idle_i, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    chk("reset.ex_ready", 64'(ex_ready), 64'h1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors, each issued from an idle stage with the consumer ready.
    for (int k = 0; k < 12; k++) begin
      drive(vecs[k].in, 1'b1);
      mem_ready = 1'b1;
      @(posedge clk); #1;
      drive(idle_i, 1'b0);
      chk($sformatf("v%0d.valid", k), 64'(mem_valid), 64'h1);
      check_bundle($sformatf("v%0d", k), vecs[k].ex);
      chk($sformatf("v%0d.redir", k), 64'(redirect_valid), 64'(vecs[k].ex.redir));
      if (vecs[k].ex.redir) chk($sformatf("v%0d.rpc", k), redirect_pc, vecs[k].ex.rpc);
      @(posedge clk); #1;
      chk($sformatf("v%0d.drain", k), 64'(mem_valid | redirect_valid), 64'h0);
    end

    // Shadow instruction following a taken branch is squashed.
    drive(vecs[2].in, 1'b1); mem_ready = 1'b1;
    @(posedge clk); #1;
    drive(ld_i, 1'b1);
    #1;
    chk("squash.redir", 64'(redirect_valid), 64'h1);
    chk("squash.ex_ready", 64'(ex_ready), 64'h1);
    @(posedge clk); #1;
    drive(idle_i, 1'b0);
    chk("squash.valid", 64'(mem_valid), 64'h0);
    chk("squash.redir_end", 64'(redirect_valid), 64'h0);
    @(posedge clk); #1;

    // Taken branch stalled for 3 cycles after its redirect: one pulse, outputs held.
    drive(br_i, 1'b1); mem_ready = 1'b0;
    @(posedge clk); #1;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      drive(ld_i, 1'b1);
      #1;
      if (redirect_valid) pulses++;
      if (k == 0) chk("stall.rpc", redirect_pc, 64'h420);
      chk($sformatf("stall%0d.ex_ready", k), 64'(ex_ready), (k == 0) ? 64'h1 : 64'h0);
      chk($sformatf("stall%0d.valid", k), 64'(mem_valid), 64'h1);
      chk($sformatf("stall%0d.addr", k), mem_addr, 64'h55);
      chk($sformatf("stall%0d.wb", k), mem_wb_data, 64'h55);
      chk($sformatf("stall%0d.rd", k), 64'(mem_rd), 64'h7);
      @(posedge clk); #1;
    end
    chk("stall.pulses", 64'(pulses), 64'h1);
    drive(idle_i, 1'b0); mem_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall.release", 64'(mem_valid), 64'h0);

    // Reset while a redirect pulse and a stalled bundle are both live.
    drive(br_i, 1'b1); mem_ready = 1'b0;
    @(posedge clk); #1;
    chk("rstmid.redir", 64'(redirect_valid), 64'h1);
    drive(idle_i, 1'b0); rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_zero("rstmid");
    @(posedge clk); #1;
    chk("rstmid.after", 64'(redirect_valid | mem_valid), 64'h0);
    mem_ready = 1'b1;
    @(posedge clk); #1;

    // Randomized traffic against the transaction-level model.
    mv = 1'b0; rv = 1'b0;
    cur = mk_exp(64'h0, 64'h0, 64'h0, 64'h0, 8'h00, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      chk("rnd.valid", 64'(mem_valid), 64'(mv));
      chk("rnd.redir", 64'(redirect_valid), 64'(rv));
      if (rv) chk("rnd.rpc", redirect_pc, cur.rpc);
      if (mv) check_bundle("rnd", cur);
      ri   = rnd_ins();
      ev   = ($urandom % 10) < 7;
      mrdy = ($urandom % 10) < 6;
      drive(ri, ev);
      mem_ready = mrdy;
      #1;
      exp_ready = rv | ~mv | mrdy;
      chk("rnd.ex_ready", 64'(ex_ready), 64'(exp_ready));
      cap = ev & exp_ready & ~rv;
      if (cap) begin
        cur = ref_fn(ri);
        mv  = 1'b1;
        rv  = cur.redir;
      end else begin
        if (mrdy) mv = 1'b0;
        rv = 1'b0;
      end
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exe_mem_stage.md
Name: exe_mem_stage

Overview:
- Pipeline stage directly downstream of the integer ALU.
- Registers the ALU result and zero flag together with the EX-stage control bundle into the EX/MEM boundary.
- Resolves branches and jumps from the ALU zero flag, issues a one-cycle PC redirect, and squashes the shadow instruction.
- Produces aligned store data, byte enables and misalignment exceptions for the data-memory stage.

Parameters:
- N, 64, datapath/XLEN and PC width.
- LINK_OFFSET, 4, added to PC to form the JAL/JALR link value.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  EX bundle valid.
- ex_ready  out  1  stage can accept EX bundle this cycle.
- ex_alu_result  in  N  ALU result: address, data, or JALR target rs1+imm.
- ex_zero  in  1  ALU compare flag; 1 = branch condition true.
- ex_pc  in  N  PC of instruction.
- ex_imm  in  N  sign-extended immediate.
- ex_rs2_data  in  N  store data.
- ex_rd  in  5  destination register.
- ex_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
- ex_is_branch, ex_is_jal, ex_is_jalr, ex_mem_read, ex_mem_write, ex_reg_write  in  1 each  decoded control.
- mem_valid  out  1  registered bundle valid.
- mem_ready  in  1  MEM stage accepts bundle.
- mem_addr  out  N  registered ALU result.
- mem_wdata  out  N  store data shifted to byte lane (addr[2:0]).
- mem_be  out  8  byte enables.
- mem_wb_data  out  N  ALU result, or pc+LINK_OFFSET for JAL/JALR.
- mem_rd  out  5; mem_funct3 out 3; mem_mem_read, mem_mem_write, mem_reg_write  out  1 each.
- mem_exc  out  2  0 none, 1 target misaligned, 2 load misaligned, 3 store misaligned.
- redirect_valid  out  1  one-cycle PC redirect pulse.
- redirect_pc  out  N  redirect target.

Behaviour:
- Reset: all outputs 0; mem_valid=0; redirect_valid=0; internal registers cleared.
- ex_ready = redirect_valid | ~mem_valid | mem_ready.
- Accept = ex_valid & ex_ready.
  - An accept while redirect_valid=1 is a squash: bundle dropped, mem_valid not set by it.
- Otherwise, on accept: capture full bundle. mem_valid becomes 1 next cycle. Latency 1 cycle.
- Stall: mem_valid & ~mem_ready & ~redirect_valid → all mem_* outputs hold stable and ex_ready=0.
- mem_valid falls when mem_ready=1 and no new non-squashed accept occurs in the same cycle.
- Taken condition: (is_branch & ex_zero) | is_jal | is_jalr.
- Target:
  - Branch/JAL: pc+imm, modulo 2^N.
  - JALR: alu_result with bit0 cleared.
- Taken with no exception:
  - redirect_valid=1 and redirect_pc=target in the cycle after capture, for exactly one cycle regardless of mem_ready.
  - Redirect issues once per instruction, including when that instruction is stalled.
- Target bit1=1 on a taken branch/jump:
  - mem_exc=1; no redirect.
  - reg_write, mem_read, mem_write forced 0.
  - Not-taken branches never raise exc 1.
- Load/store alignment: required alignment is 1/2/4/8 bytes for B/H/W/D.
  - Violation → mem_exc=2 for loads, 3 for stores.
  - mem_read, mem_write, reg_write forced 0.
  - mem_be=0.
- Byte enables for stores: mask 0x01/0x03/0x0F/0xFF shifted left by addr[2:0].
  - mem_wdata = rs2_data << (8*addr[2:0]).
  - Loads and non-memory ops: mem_be=0, mem_wdata=0.
- mem_wb_data = pc+LINK_OFFSET for JAL/JALR, else alu_result.
- Only one exception code per bundle. Priority: target misaligned over load/store misaligned.
- Reset mid-stall or mid-redirect: everything clears next edge; no redirect pulse survives reset.

Test Plan:
- Load then store: LD addr 0x1000 captured → next cycle mem_valid=1, mem_addr=0x1000, mem_be=0, exc=0. SW addr 0x1004, rs2=0xAABBCCDD → mem_be=0xF0, mem_wdata=0xAABBCCDD_00000000.
- BEQ taken: pc=0x200, imm=0x40, zero=1 → redirect_valid pulses 1 cycle, redirect_pc=0x240. Following ex_valid bundle squashed (mem_valid=0 for it); ex_ready=1 during the pulse.
- Not-taken branch and JALR:
  - BEQ with zero=0, imm=0x42 → no redirect, exc=0.
  - JALR alu_result=0x301, pc=0x100 → redirect_pc=0x300, mem_wb_data=0x104, reg_write=1.
- Stall: mem_ready=0 for 3 cycles with bundle held → outputs constant, ex_ready=0. Taken branch captured before the stall → redirect pulses only once.
- Misalignment:
  - SH at 0x1003 → exc=3, mem_write=0, mem_be=0.
  - LW at 0x1002 → exc=2, mem_read=0, reg_write=0.
  - JAL target 0x202 → exc=1, no redirect.
- Reset: rst during a redirect pulse with a stalled bundle → next cycle mem_valid=0, redirect_valid=0, all outputs 0.
